// File: rtl/satagtx_rst_seq.sv
// -----------------------------------------------------------------------------
// satagtx_rst_seq
//
// Reset sequencer for GTX tile0. Brings the tile up in the following order:
// tile GTXRESET pulse, wait for the tile PLL, then wait for a stable user-clock
// DCM lock, then pulse TXRESET/RXRESET. It waits for both channels' RESETDONE
// and reports link_rdy to the SATA link layer. Timeouts and lock loss go through
// a one-cycle RETRY state, with a bounded retry count before it parks in FAIL.
//
// Optional build macro: SATAGTX_RST_STATUS_EN
//   When defined, adds dbg_state[2:0], dbg_retry[2:0] and a sticky lock_lost
//   output. Sequencing is identical with or without it.
//
// Parameters
//   C_FAMILY      device family tag, no functional effect
//   C_GTXRST_CYC  clk cycles GTXRESET is held in GTXRST (>= 1)
//   C_LOCK_CYC    consecutive clk cycles of dcm_locked before user resets (>= 1)
//   C_USRRST_CYC  clk cycles TXRESET/RXRESET are held in USRRST (>= 1)
//   C_TMO_CYC     length, in clk cycles, of each wait state before timeout (>= 1)
//   C_MAX_RETRY   retries allowed before FAIL (0..7)
//
// Ports
//   clk         in   free-running system clock, independent of GTX clocks
//   rst_n       in   asynchronous active-low reset
//   plllkdet    in   GTX tile PLL lock (async, synchronized here)
//   dcm_locked  in   user-clock DCM lock (async, synchronized here)
//   resetdone0  in   channel 0 RESETDONE (async, synchronized here)
//   resetdone1  in   channel 1 RESETDONE (async, synchronized here)
//   restart     in   one-cycle clk-synchronous pulse: restart, clear retry count
//   gtxreset    out  tile GTXRESET
//   txreset     out  TXRESET for both channels
//   rxreset     out  RXRESET for both channels
//   link_rdy    out  high only while in READY
//   fail        out  high only while in FAIL
//   dbg_state   out  (macro only) FSM state, GTXRST=0 ... FAIL=7
//   dbg_retry   out  (macro only) current retry count
//   lock_lost   out  (macro only) sticky: lock lost while READY
//
// All outputs are registered from the current state, so each output changes
// on the cycle after its state is entered.
// -----------------------------------------------------------------------------
module satagtx_rst_seq #(
  parameter string       C_FAMILY     = "none",
  parameter int unsigned C_GTXRST_CYC = 16,
  parameter int unsigned C_LOCK_CYC   = 1024,
  parameter int unsigned C_USRRST_CYC = 8,
  parameter int unsigned C_TMO_CYC    = 65535,
  parameter int unsigned C_MAX_RETRY  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       plllkdet,
  input  logic       dcm_locked,
  input  logic       resetdone0,
  input  logic       resetdone1,
  input  logic       restart,
  output logic       gtxreset,
  output logic       txreset,
  output logic       rxreset,
  output logic       link_rdy,
`ifdef SATAGTX_RST_STATUS_EN
  output logic [2:0] dbg_state,
  output logic [2:0] dbg_retry,
  output logic       lock_lost,
`endif
  output logic       fail
);

  localparam logic [2:0] S_GTXRST    = 3'd0;
  localparam logic [2:0] S_WAIT_PLL  = 3'd1;
  localparam logic [2:0] S_WAIT_DCM  = 3'd2;
  localparam logic [2:0] S_USRRST    = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_RETRY     = 3'd6;
  localparam logic [2:0] S_FAIL      = 3'd7;

  // Counters hold "cycles already spent", so a state that must last N cycles
  // leaves when the count reaches N-1.
  localparam logic [15:0] GTXRST_LAST = 16'(C_GTXRST_CYC - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(C_LOCK_CYC - 1);
  localparam logic [15:0] USRRST_LAST = 16'(C_USRRST_CYC - 1);
  localparam logic [15:0] TMO_LAST    = 16'(C_TMO_CYC - 1);
  localparam logic [2:0]  MAX_RETRY   = 3'(C_MAX_RETRY);

  // The family tag only labels the elaborated hierarchy.
  if (C_FAMILY == "none") begin : g_family_none
  end else begin : g_family_tagged
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] sat_inc_retry(input logic [2:0] v);
    return (v >= MAX_RETRY) ? v : v + 3'd1;
  endfunction

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] timer;
  logic [15:0] lock_cnt;
  logic [2:0]  retry;

  logic rst_p0, rst_p1;
  logic pll_p0, pll_p1;
  logic dcm_p0, dcm_p1;
  logic done0_p0, done0_p1;
  logic done1_p0, done1_p1;

  logic rst_ok;
  logic pll_s;
  logic dcm_s;
  logic done_s;
  logic tmo;

  // ---- stage p0/p1: reset-release and input synchronizers ----
  // Assertion is asynchronous; release is seen by the FSM two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_p0 <= 1'b0;
      rst_p1 <= 1'b0;
    end else begin
      rst_p0 <= 1'b1;
      rst_p1 <= rst_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_p0 <= 1'b0;
      pll_p1 <= 1'b0;
    end else begin
      pll_p0 <= plllkdet;
      pll_p1 <= pll_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcm_p0 <= 1'b0;
      dcm_p1 <= 1'b0;
    end else begin
      dcm_p0 <= dcm_locked;
      dcm_p1 <= dcm_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_p0 <= 1'b0;
      done0_p1 <= 1'b0;
      done1_p0 <= 1'b0;
      done1_p1 <= 1'b0;
    end else begin
      done0_p0 <= resetdone0;
      done0_p1 <= done0_p0;
      done1_p0 <= resetdone1;
      done1_p1 <= done1_p0;
    end
  end

  assign rst_ok = rst_p1;
  assign pll_s  = pll_p1;
  assign dcm_s  = dcm_p1;
  assign done_s = done0_p1 & done1_p1;
  assign tmo    = (timer >= TMO_LAST);

  // ---- stage p2: sequencing FSM ----
  always_comb begin
    state_nx = state;
    case (state)
      S_GTXRST: begin
        // The hold timer runs during reset-release synchronization, but the
        // state is never left before that synchronization has completed.
        if (rst_ok && (timer >= GTXRST_LAST)) state_nx = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        if (pll_s)    state_nx = S_WAIT_DCM;
        else if (tmo) state_nx = S_RETRY;
      end
      S_WAIT_DCM: begin
        // Lock loss and timeout share one exit so a coincident pair retries once.
        if (!pll_s || tmo)                        state_nx = S_RETRY;
        else if (dcm_s && (lock_cnt >= LOCK_LAST)) state_nx = S_USRRST;
      end
      S_USRRST: begin
        if (timer >= USRRST_LAST) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_s)   state_nx = S_READY;
        else if (tmo) state_nx = S_RETRY;
      end
      S_READY: begin
        if (!pll_s || !dcm_s) state_nx = S_RETRY;
      end
      S_RETRY: begin
        state_nx = (retry >= MAX_RETRY) ? S_FAIL : S_GTXRST;
      end
      S_FAIL: begin
        state_nx = S_FAIL;
      end
      default: state_nx = S_GTXRST;
    endcase
    if (restart) state_nx = S_GTXRST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_GTXRST;
      timer    <= '0;
      lock_cnt <= '0;
      retry    <= '0;
    end else begin
      state <= state_nx;

      if (restart || (state_nx != state)) timer <= '0;
      else                                timer <= sat_inc16(timer);

      // Counts consecutive synced-lock samples taken while staying in WAIT_DCM.
      if ((state == S_WAIT_DCM) && (state_nx == S_WAIT_DCM) && dcm_s)
        lock_cnt <= sat_inc16(lock_cnt);
      else
        lock_cnt <= '0;

      if (restart)                retry <= '0;
      else if (state == S_RETRY)  retry <= sat_inc_retry(retry);
    end
  end

  // ---- stage p3: registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gtxreset <= 1'b1;
      txreset  <= 1'b1;
      rxreset  <= 1'b1;
      link_rdy <= 1'b0;
      fail     <= 1'b0;
    end else begin
      gtxreset <= (state == S_GTXRST) || (state == S_RETRY) || (state == S_FAIL);
      txreset  <= !((state == S_WAIT_DONE) || (state == S_READY));
      rxreset  <= !((state == S_WAIT_DONE) || (state == S_READY));
      link_rdy <= (state == S_READY);
      fail     <= (state == S_FAIL);
    end
  end

`ifdef SATAGTX_RST_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     lock_lost <= 1'b0;
    else if (restart)                               lock_lost <= 1'b0;
    else if ((state == S_READY) && (!pll_s || !dcm_s)) lock_lost <= 1'b1;
  end

  assign dbg_state = state;
  assign dbg_retry = retry;
`endif

endmodule

// File: tb/tb_satagtx_rst_seq.sv
`timescale 1ns/1ps
// Bench for satagtx_rst_seq. The timeout is shortened to 2000 cycles and the
// retry limit to 2 so the never-locking PLL case finishes quickly, while still
// leaving room for the 1024-cycle DCM stability window.
// Expected output edges are queued as {cycle, outputs} when each phase's
// stimulus is issued; a monitor pops one entry whenever the outputs change.
// Output vector order: {gtxreset, txreset, rxreset, link_rdy, fail}.
module tb_satagtx_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n      = 1'b1;
  logic plllkdet   = 1'b0;
  logic dcm_locked = 1'b0;
  logic resetdone0 = 1'b0;
  logic resetdone1 = 1'b0;
  logic restart    = 1'b0;
  logic gtxreset, txreset, rxreset, link_rdy, fail;
`ifdef SATAGTX_RST_STATUS_EN
  logic [2:0] dbg_state;
  logic [2:0] dbg_retry;
  logic       lock_lost;
`endif

  satagtx_rst_seq #(
    .C_FAMILY    ("none"),
    .C_GTXRST_CYC(16),
    .C_LOCK_CYC  (1024),
    .C_USRRST_CYC(8),
    .C_TMO_CYC   (2000),
    .C_MAX_RETRY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .plllkdet  (plllkdet),
    .dcm_locked(dcm_locked),
    .resetdone0(resetdone0),
    .resetdone1(resetdone1),
    .restart   (restart),
    .gtxreset  (gtxreset),
    .txreset   (txreset),
    .rxreset   (rxreset),
    .link_rdy  (link_rdy),
`ifdef SATAGTX_RST_STATUS_EN
    .dbg_state (dbg_state),
    .dbg_retry (dbg_retry),
    .lock_lost (lock_lost),
`endif
    .fail      (fail)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int         exp_cyc_q[$];
  logic [4:0] exp_val_q[$];
  string      exp_tag_q[$];

  logic       mon_en = 1'b0;
  logic [4:0] prev_out = 5'b11100;
  wire  [4:0] out_v = {gtxreset, txreset, rxreset, link_rdy, fail};

  task automatic push_exp(input int c, input logic [4:0] v, input string tag);
    exp_cyc_q.push_back(c);
    exp_val_q.push_back(v);
    exp_tag_q.push_back(tag);
  endtask

  // Returns at the falling edge following posedge number n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_done(input logic v);
    resetdone0 = v;
    resetdone1 = v;
  endtask

  // Monitor: one scoreboard entry consumed per output change.
  always begin
    @(posedge clk);
    #1;
    if (mon_en && (out_v !== prev_out)) begin
      n_tests++;
      if (exp_cyc_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: outputs %b at cycle %0d, required to stay %b",
                 out_v, cyc, prev_out);
      end else begin
        int         c;
        logic [4:0] v;
        string      t;
        c = exp_cyc_q.pop_front();
        v = exp_val_q.pop_front();
        t = exp_tag_q.pop_front();
        if ((cyc != c) || (out_v !== v)) begin
          n_fail++;
          $display("FAIL %s: outputs %b at cycle %0d, required %b at cycle %0d",
                   t, out_v, cyc, v, c);
        end
      end
      prev_out = out_v;
    end
  end

  int b, c, p, q, s, r;

  initial begin
    #1 rst_n = 1'b0;
    wait_cyc(3);
    n_tests++;
    if (out_v !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_state: outputs %b, required %b", out_v, 5'b11100);
    end
    prev_out = out_v;
    mon_en   = 1'b1;

    // Nominal bring-up.
    b = 5;
    push_exp(b + 17,   5'b01100, "A_gtxreset_release");
    push_exp(b + 1235, 5'b00000, "A_usrreset_release");
    push_exp(b + 1504, 5'b00010, "A_link_rdy");
    wait_cyc(b);        rst_n = 1'b1;
    wait_cyc(b + 100);  plllkdet = 1'b1;
    wait_cyc(b + 200);  dcm_locked = 1'b1;
    wait_cyc(b + 1500); set_done(1'b1);

    // PLL loss in READY, then a one-cycle DCM glitch at stable count 500
    // during the re-lock.
    c = b + 1600;
    push_exp(c + 4,    5'b11100, "B_lockloss_retry");
    push_exp(c + 21,   5'b01100, "B_gtxreset_release");
    push_exp(c + 1555, 5'b00000, "C_usrreset_after_glitch");
    push_exp(c + 1604, 5'b00010, "B_link_rdy_again");
    wait_cyc(c);        plllkdet = 1'b0; set_done(1'b0);
    wait_cyc(c + 10);   plllkdet = 1'b1;
    wait_cyc(c + 519);  dcm_locked = 1'b0;
    wait_cyc(c + 520);  dcm_locked = 1'b1;
    wait_cyc(c + 1600); set_done(1'b1);

    // Restart with the PLL never locking: three attempts, then FAIL.
    p = c + 1700;
    push_exp(p + 2,    5'b11100, "D_restart_gtxreset");
    push_exp(p + 18,   5'b01100, "D_attempt0_release");
    push_exp(p + 2018, 5'b11100, "D_retry1_gtxreset");
    push_exp(p + 2035, 5'b01100, "D_attempt1_release");
    push_exp(p + 4035, 5'b11100, "D_retry2_gtxreset");
    push_exp(p + 4052, 5'b01100, "D_attempt2_release");
    push_exp(p + 6052, 5'b11100, "D_final_retry");
    push_exp(p + 6053, 5'b11101, "D_fail");
    wait_cyc(p);        plllkdet = 1'b0; set_done(1'b0); restart = 1'b1;
    wait_cyc(p + 1);    restart = 1'b0;
    wait_cyc(p + 6100); plllkdet = 1'b1;

    // Restart out of FAIL with good locks.
    q = p + 6200;
    push_exp(q + 2,    5'b11100, "E_restart_clears_fail");
    push_exp(q + 18,   5'b01100, "E_gtxreset_release");
    push_exp(q + 1051, 5'b00000, "E_usrreset_release");
    push_exp(q + 1104, 5'b00010, "E_link_rdy");
    wait_cyc(q);        restart = 1'b1;
    wait_cyc(q + 1);    restart = 1'b0;
    wait_cyc(q + 1100); set_done(1'b1);

    // Reach WAIT_DONE again, then pulse rst_n for one cycle.
    s = q + 1200;
    r = s + 1100;
    push_exp(s + 2,    5'b11100, "F_restart_gtxreset");
    push_exp(s + 18,   5'b01100, "F_gtxreset_release");
    push_exp(s + 1051, 5'b00000, "F_wait_done");
    push_exp(r + 1,    5'b11100, "F_rst_n_pulse");
    push_exp(r + 18,   5'b01100, "F_post_reset_release");
    push_exp(r + 1051, 5'b00000, "F_post_reset_usr_release");
    push_exp(r + 1105, 5'b00010, "F_post_reset_link_rdy");
    wait_cyc(s);        set_done(1'b0); restart = 1'b1;
    wait_cyc(s + 1);    restart = 1'b0;
    wait_cyc(r);        rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_v !== 5'b11100) begin
      n_fail++;
      $display("FAIL async_reset_assert: outputs %b, required %b", out_v, 5'b11100);
    end
    wait_cyc(r + 1);    rst_n = 1'b1;
    wait_cyc(r + 1101); set_done(1'b1);
    wait_cyc(r + 1140);

    while (exp_cyc_q.size() != 0) begin
      int         mc;
      logic [4:0] mv;
      string      mt;
      mc = exp_cyc_q.pop_front();
      mv = exp_val_q.pop_front();
      mt = exp_tag_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: no output change seen, required %b at cycle %0d", mt, mv, mc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
